msu_ckpt: RTL and testbench

Parametrised successor to the single-shot MSU AXI-stream controller. Receives a job (`t_start`, `t_final`, `sq_in`) over AXI-stream and drives an external modular-squaring core through a start/valid handshake. Returns the final result, plus optional intermediate checkpoint packets every `CKPT_INTERVAL` iterations. Sits between the host DMA streams and the squarer wrapper, replacing the fixed-format controller.

---
 rtl/msu_ckpt.sv | 267 ++++++++++++++++++++++++++
 tb/tb_msu_ckpt.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msu_ckpt.sv
// msu_ckpt -- AXI-stream job controller for an external modular-squaring core,
// with optional intermediate checkpoint packets.
//
// A job arrives as one input packet: t_start, t_final, sq_in (lowest word
// first). The controller starts the squarer and counts completed squarings
// until t_final is reached. It then returns the final packet:
//   word 0  : status (bit0 = final, bit1 = checkpoints were dropped)
//   words.. : t, T_LEN/AXI_LEN words
//   words.. : squarer value, SQO_W words, top bits zero
// Every CKPT_INTERVAL iterations it can also emit a checkpoint packet with
// the same layout and status 0.
//
// Optional feature macro: MSU_CKPT_EN.
//   defined   : checkpoint packets and ckpt_drop_count are active.
//   undefined : only the final packet is sent; ckpt_drop_count is 0.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   ap_start / ap_done         job start request / one-cycle done pulse
//   start_xfer                 one-cycle pulse when the final packet is loaded
//   s_axis_*                   job input stream (tready driven here)
//   s_axis_xfer_size_in_bytes  constant input packet size in bytes
//   m_axis_*                   result output stream (tkeep always all-ones)
//   m_axis_xfer_size_in_bytes  constant output packet size in bytes
//   sq_reset, sq_start, sq_in  squarer control and operand
//   sq_out, sq_valid           squarer result, one sq_valid per squaring
//   ckpt_drop_count            saturating count of skipped checkpoints
//
// Stream handshake (both directions): a word moves on a rising clk edge
// where tvalid and tready are both high. While tvalid is high and tready is
// low, tdata and tlast hold steady; tvalid never drops without a transfer.
//
// The FSM state is held in `state` (type state_t) for external observation.
module msu_ckpt #(
   parameter int AXI_LEN           = 32,
   parameter int C_XFER_SIZE_WIDTH = 32,
   parameter int T_LEN             = 64,
   parameter int SQ_IN_BITS        = 1024,
   parameter int SQ_OUT_BITS       = 1056,
   parameter int CKPT_INTERVAL     = 1024,
   parameter int DROP_W            = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         ap_start,
   output logic                         ap_done,
   output logic                         start_xfer,
   input  logic                         s_axis_tvalid,
   input  logic [AXI_LEN-1:0]           s_axis_tdata,
   input  logic                         s_axis_tlast,
   output logic                         s_axis_tready,
   output logic [C_XFER_SIZE_WIDTH-1:0] s_axis_xfer_size_in_bytes,
   output logic                         m_axis_tvalid,
   input  logic                         m_axis_tready,
   output logic [AXI_LEN-1:0]           m_axis_tdata,
   output logic [AXI_LEN/8-1:0]         m_axis_tkeep,
   output logic                         m_axis_tlast,
   output logic [C_XFER_SIZE_WIDTH-1:0] m_axis_xfer_size_in_bytes,
   output logic                         sq_reset,
   output logic                         sq_start,
   output logic [SQ_IN_BITS-1:0]        sq_in,
   input  logic [SQ_OUT_BITS-1:0]       sq_out,
   input  logic                         sq_valid,
   output logic [DROP_W-1:0]            ckpt_drop_count
);

   localparam int SQI_W     = (SQ_IN_BITS + AXI_LEN - 1) / AXI_LEN;
   localparam int SQO_W     = (SQ_OUT_BITS + AXI_LEN - 1) / AXI_LEN;
   localparam int T_WORDS   = T_LEN / AXI_LEN;
   localparam int IN_WORDS  = 2 * T_WORDS + SQI_W;
   localparam int OUT_WORDS = 1 + T_WORDS + SQO_W;
   localparam int IN_W      = IN_WORDS * AXI_LEN;
   localparam int OUT_W     = OUT_WORDS * AXI_LEN;
   localparam int SQO_PAD   = SQO_W * AXI_LEN;
   localparam int CNT_W     = $clog2(OUT_WORDS + 1);

   // Elaboration-time guard against unusable parameter sets.
   if (CKPT_INTERVAL < 2 || (T_LEN % AXI_LEN) != 0 || SQ_OUT_BITS < SQ_IN_BITS) begin : g_bad_cfg
      $error("msu_ckpt: unsupported parameter combination");
   end

   typedef enum logic [2:0] {
      S_INIT, S_RECV, S_LOAD, S_START, S_COMPUTE, S_FINAL, S_SEND, S_DONE
   } state_t;

   state_t                 state;
   logic [IN_W-1:0]        in_sr;
   logic [T_LEN-1:0]       t_cur;
   logic [T_LEN-1:0]       t_final_r;
   logic [T_LEN-1:0]       hold_t;
   logic [SQ_OUT_BITS-1:0] hold_v;
   logic [OUT_W-1:0]       out_sr;
   logic [CNT_W-1:0]       out_left;   // words still to send, including the one on the bus
   logic                   drop_nz;

   // Job fields as they sit in the input shifter after a full packet.
   logic [T_LEN-1:0]       f_t_start;
   logic [T_LEN-1:0]       f_t_final;
   logic [SQ_IN_BITS-1:0]  f_sq_in;
   logic [T_LEN-1:0]       t_next;

   assign f_t_start = in_sr[T_LEN-1:0];
   assign f_t_final = in_sr[2*T_LEN-1:T_LEN];
   assign f_sq_in   = in_sr[2*T_LEN +: SQ_IN_BITS];
   assign t_next    = t_cur + T_LEN'(1);

   assign s_axis_xfer_size_in_bytes = C_XFER_SIZE_WIDTH'(IN_WORDS * AXI_LEN / 8);
   assign m_axis_xfer_size_in_bytes = C_XFER_SIZE_WIDTH'(OUT_WORDS * AXI_LEN / 8);
   assign m_axis_tkeep              = '1;
   assign m_axis_tdata              = out_sr[AXI_LEN-1:0];
   assign m_axis_tlast              = m_axis_tvalid && (out_left == CNT_W'(1));

`ifdef MSU_CKPT_EN
   localparam int CK_W = $clog2(CKPT_INTERVAL);
   logic [CK_W-1:0]   ckpt_cnt;   // squarings left until the next checkpoint is due
   logic [DROP_W-1:0] drop_cnt;
   assign ckpt_drop_count = drop_cnt;
   assign drop_nz         = |drop_cnt;
`else
   assign ckpt_drop_count = '0;
   assign drop_nz         = 1'b0;
`endif

   // Packet image, word 0 in the low bits so the shifter sends it first.
   function automatic logic [OUT_W-1:0] pack_pkt(input logic [1:0]             status,
                                                 input logic [T_LEN-1:0]       t,
                                                 input logic [SQ_OUT_BITS-1:0] v);
      logic [AXI_LEN-1:0] sw;
      logic [SQO_PAD-1:0] vw;
      sw      = '0;
      sw[1:0] = status;
      vw      = '0;
      vw[SQ_OUT_BITS-1:0] = v;
      return {vw, t, sw};
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_INIT;
         s_axis_tready <= 1'b0;
         m_axis_tvalid <= 1'b0;
         out_left      <= '0;
         out_sr        <= '0;
         sq_start      <= 1'b0;
         sq_reset      <= 1'b1;
         ap_done       <= 1'b0;
         start_xfer    <= 1'b0;
         in_sr         <= '0;
         t_cur         <= '0;
         t_final_r     <= '0;
         sq_in         <= '0;
         hold_t        <= '0;
         hold_v        <= '0;
`ifdef MSU_CKPT_EN
         ckpt_cnt      <= '0;
         drop_cnt      <= '0;
`endif
      end else begin
         sq_start   <= 1'b0;
         ap_done    <= 1'b0;
         start_xfer <= 1'b0;

         // Output shifter drain. Loads below happen only while it is idle,
         // so they never collide with a shift.
         if (m_axis_tvalid && m_axis_tready) begin
            if (out_left == CNT_W'(1)) begin
               m_axis_tvalid <= 1'b0;
            end else begin
               out_sr   <= out_sr >> AXI_LEN;
               out_left <= out_left - CNT_W'(1);
            end
         end

         case (state)
            S_INIT: begin
               if (ap_start) begin
                  state         <= S_RECV;
                  s_axis_tready <= 1'b1;
               end
            end

            S_RECV: begin
               if (s_axis_tvalid && s_axis_tready) begin
                  in_sr <= {s_axis_tdata, in_sr[IN_W-1:AXI_LEN]};
                  if (s_axis_tlast) begin
                     state         <= S_LOAD;
                     s_axis_tready <= 1'b0;
                  end
               end
            end

            S_LOAD: begin
               t_cur     <= f_t_start;
               t_final_r <= f_t_final;
               sq_in     <= f_sq_in;
`ifdef MSU_CKPT_EN
               ckpt_cnt  <= CK_W'(CKPT_INTERVAL - 1);
               drop_cnt  <= '0;
`endif
               if (f_t_start == f_t_final) begin
                  // Nothing to square: the operand itself is the result.
                  hold_t <= f_t_start;
                  hold_v <= SQ_OUT_BITS'(f_sq_in);
                  state  <= S_FINAL;
               end else begin
                  state    <= S_START;
                  sq_start <= 1'b1;
                  sq_reset <= 1'b0;
               end
            end

            S_START: state <= S_COMPUTE;

            S_COMPUTE: begin
               if (sq_valid) begin
                  t_cur <= t_next;
                  if (t_next == t_final_r) begin
                     hold_t   <= t_next;
                     hold_v   <= sq_out;
                     state    <= S_FINAL;
                     sq_reset <= 1'b1;
                  end
`ifdef MSU_CKPT_EN
                  else if (ckpt_cnt == '0) begin
                     ckpt_cnt <= CK_W'(CKPT_INTERVAL - 1);
                     // Busy means tvalid is still high, even if its last word
                     // leaves on this very edge; the squarer is never stalled.
                     if (!m_axis_tvalid) begin
                        out_sr        <= pack_pkt(2'b00, t_next, sq_out);
                        out_left      <= CNT_W'(OUT_WORDS);
                        m_axis_tvalid <= 1'b1;
                     end else if (drop_cnt != '1) begin
                        drop_cnt <= drop_cnt + DROP_W'(1);
                     end
                  end else begin
                     ckpt_cnt <= ckpt_cnt - CK_W'(1);
                  end
`endif
               end
            end

            S_FINAL: begin
               // Any checkpoint in flight drains completely first.
               if (!m_axis_tvalid) begin
                  out_sr        <= pack_pkt({drop_nz, 1'b1}, hold_t, hold_v);
                  out_left      <= CNT_W'(OUT_WORDS);
                  m_axis_tvalid <= 1'b1;
                  start_xfer    <= 1'b1;
                  state         <= S_SEND;
               end
            end

            S_SEND: begin
               if (m_axis_tvalid && m_axis_tready && out_left == CNT_W'(1)) begin
                  state   <= S_DONE;
                  ap_done <= 1'b1;
               end
            end

            S_DONE:  state <= S_INIT;

            default: state <= S_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_msu_ckpt.sv
// Self-checking bench for msu_ckpt with small parameters (CKPT_INTERVAL=4,
// 64-bit operand, 80-bit result, 4-bit drop counter). Output words are
// checked against an expected-word queue filled from a job-level model.
module tb_msu_ckpt;

   localparam int AXI   = 32;
   localparam int TL    = 64;
   localparam int SQI   = 64;
   localparam int SQO   = 80;
   localparam int CKI   = 4;
   localparam int DW    = 4;
   localparam int SQI_W = (SQI + AXI - 1) / AXI;
   localparam int SQO_W = (SQO + AXI - 1) / AXI;
   localparam int IN_WORDS  = 2 * TL / AXI + SQI_W;
   localparam int OUT_WORDS = 1 + TL / AXI + SQO_W;
   localparam int IN_W  = IN_WORDS * AXI;
`ifdef MSU_CKPT_EN
   localparam bit CKPT_ON = 1'b1;
`else
   localparam bit CKPT_ON = 1'b0;
`endif

   logic            clk;
   logic            reset;
   logic            ap_start;
   logic            ap_done;
   logic            start_xfer;
   logic            s_axis_tvalid;
   logic [AXI-1:0]  s_axis_tdata;
   logic            s_axis_tlast;
   logic            s_axis_tready;
   logic [31:0]     s_axis_xfer_size_in_bytes;
   logic            m_axis_tvalid;
   logic            m_axis_tready;
   logic [AXI-1:0]  m_axis_tdata;
   logic [AXI/8-1:0] m_axis_tkeep;
   logic            m_axis_tlast;
   logic [31:0]     m_axis_xfer_size_in_bytes;
   logic            sq_reset;
   logic            sq_start;
   logic [SQI-1:0]  sq_in;
   logic [SQO-1:0]  sq_out;
   logic            sq_valid;
   logic [DW-1:0]   ckpt_drop_count;

   msu_ckpt #(
      .AXI_LEN(AXI), .C_XFER_SIZE_WIDTH(32), .T_LEN(TL), .SQ_IN_BITS(SQI),
      .SQ_OUT_BITS(SQO), .CKPT_INTERVAL(CKI), .DROP_W(DW)
   ) dut (
      .clk(clk), .reset(reset), .ap_start(ap_start), .ap_done(ap_done),
      .start_xfer(start_xfer),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
      .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
      .s_axis_xfer_size_in_bytes(s_axis_xfer_size_in_bytes),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
      .m_axis_tlast(m_axis_tlast),
      .m_axis_xfer_size_in_bytes(m_axis_xfer_size_in_bytes),
      .sq_reset(sq_reset), .sq_start(sq_start), .sq_in(sq_in),
      .sq_out(sq_out), .sq_valid(sq_valid), .ckpt_drop_count(ckpt_drop_count)
   );

   // ---------------- clock / reset / cycle count ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- bookkeeping ----------------
   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   logic [AXI-1:0] exp_q[$];
   bit             exp_last_q[$];

   // ---------------- output ready driver ----------------
   int ready_mode = 0;   // 0 always ready, 1 random (never low > 3 cycles), 2 held low
   int low_run    = 0;
   initial m_axis_tready = 1'b1;
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0: m_axis_tready = 1'b1;
         2: m_axis_tready = 1'b0;
         default: begin
            if (low_run >= 3 || $urandom_range(0, 1) == 1) begin
               m_axis_tready = 1'b1;
               low_run = 0;
            end else begin
               m_axis_tready = 1'b0;
               low_run++;
            end
         end
      endcase
   end

   // ---------------- squarer stub: value+1 every sq_period cycles ----------------
   int             sq_period = 3;
   logic           st_active = 1'b0;
   int             st_cnt = 0;
   logic [SQO-1:0] st_val = '0;
   initial begin
      sq_valid = 1'b0;
      sq_out   = '0;
   end
   always @(posedge clk) begin
      sq_valid <= 1'b0;
      if (sq_reset) begin
         st_active <= 1'b0;
         st_cnt    <= 0;
      end else if (sq_start) begin
         st_active <= 1'b1;
         st_cnt    <= 1;
         st_val    <= SQO'(sq_in);
      end else if (st_active) begin
         if (st_cnt >= sq_period - 1) begin
            st_cnt   <= 0;
            sq_valid <= 1'b1;
            sq_out   <= st_val + SQO'(1);
            st_val   <= st_val + SQO'(1);
         end else begin
            st_cnt <= st_cnt + 1;
         end
      end
   end

   // ---------------- output monitor / scoreboard ----------------
   int       done_cnt = 0;
   int       start_cnt = 0;
   int       xfer_cnt = 0;
   int       last_tlast_cyc = -10;
   int       last_valid_cyc = -10;
   bit       lat_chk = 1'b0;
   bit       prev_stall = 1'b0;
   bit       prev_tvalid = 1'b0;
   logic [AXI-1:0] prev_data = '0;
   logic     prev_last = 1'b0;
   logic [AXI-1:0] ew;
   bit       el;

   always @(negedge clk) begin
      if (reset) begin
         prev_stall  = 1'b0;
         prev_tvalid = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_tvalid", 128'(m_axis_tvalid), 128'(1));
            check("hold_tdata", 128'(m_axis_tdata), 128'(prev_data));
            check("hold_tlast", 128'(m_axis_tlast), 128'(prev_last));
         end
         if (lat_chk && m_axis_tvalid && !prev_tvalid && m_axis_tdata[0])
            check("final_latency", 128'(cyc - last_valid_cyc), 128'(2));
         if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
               check("extra_word", 128'(m_axis_tdata), 128'hdead);
            end else begin
               ew = exp_q.pop_front();
               el = exp_last_q.pop_front();
               check("out_word", 128'(m_axis_tdata), 128'(ew));
               check("out_tlast", 128'(m_axis_tlast), 128'(el));
               check("out_tkeep", 128'(m_axis_tkeep), 128'(4'hf));
            end
            if (m_axis_tlast) last_tlast_cyc = cyc;
         end
         if (ap_done) begin
            done_cnt++;
            check("done_latency", 128'(cyc - last_tlast_cyc), 128'(1));
         end
         if (sq_start)   start_cnt++;
         if (start_xfer) xfer_cnt++;
         if (sq_valid)   last_valid_cyc = cyc;
         prev_stall  = m_axis_tvalid && !m_axis_tready;
         prev_tvalid = m_axis_tvalid;
         prev_data   = m_axis_tdata;
         prev_last   = m_axis_tlast;
      end
   end

   // ---------------- reference model ----------------
   function automatic void push_pkt(input logic [1:0] st, input logic [TL-1:0] t, input logic [SQO-1:0] v);
      logic [SQO_W*AXI-1:0] vp;
      logic [AXI-1:0]       sw;
      vp = '0;
      vp[SQO-1:0] = v;
      sw = '0;
      sw[1:0] = st;
      exp_q.push_back(sw);                exp_last_q.push_back(1'b0);
      for (int i = 0; i < TL / AXI; i++) begin
         exp_q.push_back(t[i*AXI +: AXI]); exp_last_q.push_back(1'b0);
      end
      for (int i = 0; i < SQO_W; i++) begin
         exp_q.push_back(vp[i*AXI +: AXI]);
         exp_last_q.push_back(i == SQO_W - 1);
      end
   endfunction

   // Iteration k of the job yields t_start+k and sq_in+k; checkpoints fall on
   // multiples of CKI strictly before the last iteration, the first ck_limit kept.
   function automatic void expect_job(input logic [TL-1:0] ts, input logic [TL-1:0] tf,
                                      input logic [SQI-1:0] sq, input int ck_limit, input int status);
      logic [TL-1:0] n;
      logic [TL-1:0] k;
      int made;
      n = tf - ts;
      k = TL'(CKI);
      made = 0;
      while (k < n && made < ck_limit) begin
         push_pkt(2'b00, ts + k, SQO'(sq) + SQO'(k));
         k = k + TL'(CKI);
         made++;
      end
      push_pkt(status[1:0], tf, SQO'(sq) + SQO'(n));
   endfunction

   // ---------------- drivers ----------------
   task automatic send_job(input logic [TL-1:0] ts, input logic [TL-1:0] tf, input logic [SQI-1:0] sq);
      logic [IN_W-1:0] pkt;
      int guard;
      pkt = {sq, tf, ts};
      ap_start = 1'b1;
      step();
      ap_start = 1'b0;
      for (int i = 0; i < IN_WORDS; i++) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = pkt[i*AXI +: AXI];
         s_axis_tlast  = (i == IN_WORDS - 1);
         guard = 0;
         while (!s_axis_tready && guard < 100) begin
            step();
            guard++;
         end
         if (guard >= 100) check("s_tready_timeout", 128'(0), 128'(1));
         step();
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic run_job(input string tag, input logic [TL-1:0] ts, input logic [TL-1:0] tf,
                          input logic [SQI-1:0] sq, input int hold, input int ck_limit,
                          input int drops, input int status, input bit chk_lat);
      int d0, s0, x0, guard, base;
      d0 = done_cnt; s0 = start_cnt; x0 = xfer_cnt;
      base = ready_mode;
      expect_job(ts, tf, sq, ck_limit, status);
      lat_chk = chk_lat;
      if (hold > 0) ready_mode = 2;
      send_job(ts, tf, sq);
      if (hold > 0) begin
         guard = 0;
         while (start_cnt == s0 && guard < 300) begin step(); guard++; end
         if (guard >= 300) check({tag, "_sqstart_timeout"}, 128'(0), 128'(1));
         repeat (hold) step();
         ready_mode = base;
      end
      guard = 0;
      while (done_cnt == d0 && guard < 3000) begin step(); guard++; end
      if (guard >= 3000) check({tag, "_done_timeout"}, 128'(0), 128'(1));
      repeat (8) step();
      lat_chk = 1'b0;
      check({tag, "_ap_done_pulses"}, 128'(done_cnt - d0), 128'(1));
      check({tag, "_sq_start_pulses"}, 128'(start_cnt - s0), 128'((tf == ts) ? 0 : 1));
      check({tag, "_start_xfer_pulses"}, 128'(xfer_cnt - x0), 128'(1));
      check({tag, "_words_left"}, 128'(exp_q.size()), 128'(0));
      check({tag, "_drop_count"}, 128'(ckpt_drop_count), 128'(drops));
      exp_q.delete();
      exp_last_q.delete();
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_s_tready"}, 128'(s_axis_tready), 128'(0));
      check({tag, "_m_tvalid"}, 128'(m_axis_tvalid), 128'(0));
      check({tag, "_m_tlast"}, 128'(m_axis_tlast), 128'(0));
      check({tag, "_sq_start"}, 128'(sq_start), 128'(0));
      check({tag, "_ap_done"}, 128'(ap_done), 128'(0));
      check({tag, "_start_xfer"}, 128'(start_xfer), 128'(0));
      check({tag, "_sq_reset"}, 128'(sq_reset), 128'(1));
      check({tag, "_drop_count"}, 128'(ckpt_drop_count), 128'(0));
      check({tag, "_tkeep"}, 128'(m_axis_tkeep), 128'(4'hf));
      check({tag, "_in_bytes"}, 128'(s_axis_xfer_size_in_bytes), 128'(IN_WORDS * AXI / 8));
      check({tag, "_out_bytes"}, 128'(m_axis_xfer_size_in_bytes), 128'(OUT_WORDS * AXI / 8));
   endtask

   // ---------------- vector table ----------------
   // ck_n/drops/status are the expectations with checkpoints compiled in;
   // without them every job yields 0 checkpoints, 0 drops, status 1.
   typedef struct {
      logic [TL-1:0]  ts;
      logic [TL-1:0]  tf;
      logic [SQI-1:0] sq;
      int             hold;     // tready low until this many cycles after sq_start
      int             ck_n;
      int             drops;
      int             status;
      bit             chk_lat;
   } vec_t;

   vec_t vt[7];

   initial begin
      logic [TL-1:0]  rts;
      logic [SQI-1:0] rsq;
      int             rn;

      vt[0] = '{64'd0,   64'd10,  64'h0123_4567_89ab_cdef, 0,   2, 0,  1, 1'b0}; // two checkpoints
      vt[1] = '{64'd0,   64'd10,  64'h1111_2222_3333_4444, 40,  1, 1,  3, 1'b0}; // t=8 dropped
      vt[2] = '{64'd5,   64'd5,   64'hfedc_ba98_7654_3210, 0,   0, 0,  1, 1'b0}; // zero iterations
      vt[3] = '{64'd0,   64'd100, 64'h0000_0000_ffff_ffff, 400, 1, 15, 3, 1'b0}; // drop counter saturates
      vt[4] = '{64'd7,   64'd8,   64'h8000_0000_0000_0001, 0,   0, 0,  1, 1'b1}; // single iteration
      vt[5] = '{64'd3,   64'd7,   64'h5555_aaaa_5555_aaaa, 0,   0, 0,  1, 1'b1}; // due coincides with final
      vt[6] = '{64'd0,   64'd5,   64'h0f0f_0f0f_0f0f_0f0f, 0,   1, 0,  1, 1'b0}; // final waits for drain

      reset         = 1'b1;
      ap_start      = 1'b0;
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tlast  = 1'b0;
      repeat (3) step();
      check_reset_vals("por");
      reset = 1'b0;
      step();

      // Table-driven jobs, tready high except during the hold window.
      ready_mode = 0;
      sq_period  = 3;
      for (int i = 0; i < 7; i++) begin
         run_job($sformatf("vec%0d", i), vt[i].ts, vt[i].tf, vt[i].sq, vt[i].hold,
                 CKPT_ON ? vt[i].ck_n : 0, CKPT_ON ? vt[i].drops : 0,
                 CKPT_ON ? vt[i].status : 1, vt[i].chk_lat);
      end

      // Reset in the middle of COMPUTE, then a fresh job.
      begin
         int s0, guard;
         s0 = start_cnt;
         expect_job(64'd0, 64'd10, 64'h2222_3333_4444_5555, CKPT_ON ? 2 : 0, 1);
         send_job(64'd0, 64'd10, 64'h2222_3333_4444_5555);
         guard = 0;
         while (start_cnt == s0 && guard < 300) begin step(); guard++; end
         if (guard >= 300) check("midrst_sqstart_timeout", 128'(0), 128'(1));
         repeat (15) step();
         reset = 1'b1;
         step();
         check_reset_vals("midrst");
         reset = 1'b0;
         exp_q.delete();
         exp_last_q.delete();
         step();
         check("midrst_idle_tvalid", 128'(m_axis_tvalid), 128'(0));
         run_job("after_rst", vt[0].ts, vt[0].tf, vt[0].sq, 0,
                 CKPT_ON ? vt[0].ck_n : 0, 0, 1, 1'b0);
      end

      // Random jobs under random backpressure; squarings are spaced so that a
      // checkpoint always drains before the next one is due.
      ready_mode = 1;
      sq_period  = 20;
      for (int j = 0; j < 8; j++) begin
         rts = {1'b0, 31'($urandom), 32'($urandom)};
         rsq = {32'($urandom), 32'($urandom)};
         rn  = $urandom_range(0, 14);
         run_job($sformatf("rand%0d", j), rts, rts + TL'(rn), rsq, 0,
                 CKPT_ON ? 99 : 0, 0, 1, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
